// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic_tile output-stationary MAC array.
package systolic_pkg;

  localparam int DEF_D_W      = 8;
  localparam int DEF_D_W_ACC  = 32;
  localparam int DEF_N1       = 8;
  localparam int DEF_N2       = 4;
  localparam int DEF_K_MAX    = 256;
  localparam int DEF_SATURATE = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/pe_mac.sv
// One processing element: registered a/b passthrough plus a signed accumulator
// that either wraps or clamps on overflow.
module pe_mac
  import systolic_pkg::*;
#(
  parameter int D_W      = DEF_D_W,
  parameter int D_W_ACC  = DEF_D_W_ACC,
  parameter int SATURATE = DEF_SATURATE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic signed [D_W-1:0]     in_a,
  input  logic signed [D_W-1:0]     in_b,
  output logic signed [D_W-1:0]     out_a,
  output logic signed [D_W-1:0]     out_b,
  output logic signed [D_W_ACC-1:0] acc
);

  localparam logic signed [D_W_ACC-1:0] ACC_MAX = {1'b0, {(D_W_ACC-1){1'b1}}};
  localparam logic signed [D_W_ACC-1:0] ACC_MIN = {1'b1, {(D_W_ACC-1){1'b0}}};

  logic signed [D_W-1:0]     a_r;
  logic signed [D_W-1:0]     b_r;
  logic signed [D_W_ACC-1:0] acc_r;
  logic signed [2*D_W-1:0]   prod_s;

  // One guard bit above the accumulator exposes overflow as a sign disagreement.
  function automatic logic signed [D_W_ACC-1:0] acc_add(
    input logic signed [D_W_ACC-1:0] x,
    input logic signed [2*D_W-1:0]   p
  );
    logic signed [D_W_ACC:0]   sum;
    logic signed [D_W_ACC-1:0] res;
    sum = {x[D_W_ACC-1], x} + {{(D_W_ACC+1-2*D_W){p[2*D_W-1]}}, p};
    if ((SATURATE != 0) && (sum[D_W_ACC] != sum[D_W_ACC-1])) begin
      res = sum[D_W_ACC] ? ACC_MIN : ACC_MAX;
    end else begin
      res = sum[D_W_ACC-1:0];
    end
    return res;
  endfunction

  assign prod_s = (2*D_W)'(in_a) * (2*D_W)'(in_b);

  // Operand passthrough and accumulation; clear wins over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r   <= {D_W{1'b0}};
      b_r   <= {D_W{1'b0}};
      acc_r <= {D_W_ACC{1'b0}};
    end else if (clr) begin
      a_r   <= {D_W{1'b0}};
      b_r   <= {D_W{1'b0}};
      acc_r <= {D_W_ACC{1'b0}};
    end else if (en) begin
      a_r   <= in_a;
      b_r   <= in_b;
      acc_r <= acc_add(acc_r, prod_s);
    end
  end

  assign out_a = a_r;
  assign out_b = b_r;
  assign acc   = acc_r;

endmodule

// File: rtl/systolic_tile.sv
// N1 x N2 output-stationary systolic tile: skewed operand feed, accumulate over
// k_len beats, flush the wavefront, then drain one result column per beat.
module systolic_tile
  import systolic_pkg::*;
#(
  parameter int D_W      = DEF_D_W,
  parameter int D_W_ACC  = DEF_D_W_ACC,
  parameter int N1       = DEF_N1,
  parameter int N2       = DEF_N2,
  parameter int K_MAX    = DEF_K_MAX,
  parameter int SATURATE = DEF_SATURATE,
  localparam int KW      = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N1*D_W-1:0]      A,
  input  logic [N2*D_W-1:0]      B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N1*D_W_ACC-1:0]  D,
  output logic                   busy,
  output logic                   done
);

  localparam int FL = N1 + N2 - 2;
  localparam int FW = $clog2(N1 + N2);
  localparam int CW = $clog2(N2);
  localparam logic [KW-1:0] K_LIM = KW'(K_MAX);

  state_e state_r, state_n;
  logic [KW-1:0] cnt_r;
  logic [FW-1:0] flush_r;
  logic [CW-1:0] col_r;
  logic          in_ready_r, out_valid_r, busy_r, done_r;

  logic          start_s, accept_s, en_s, out_hs_s, last_col_s;
  logic [KW-1:0] k_eff_s;
  logic [N1*D_W_ACC-1:0] d_s;

  logic signed [D_W-1:0]     a_feed_s [N1];
  logic signed [D_W-1:0]     b_feed_s [N2];
  logic signed [D_W-1:0]     a_edge_s [N1];
  logic signed [D_W-1:0]     b_edge_s [N2];
  logic signed [D_W-1:0]     a_in_s   [N1][N2];
  logic signed [D_W-1:0]     b_in_s   [N1][N2];
  logic signed [D_W-1:0]     a_pe_s   [N1][N2];
  logic signed [D_W-1:0]     b_pe_s   [N1][N2];
  logic signed [D_W_ACC-1:0] acc_s    [N1][N2];

  assign start_s    = (state_r == ST_IDLE) && start;
  assign accept_s   = (state_r == ST_LOAD) && in_valid;
  assign en_s       = accept_s || (state_r == ST_FLUSH);
  assign out_hs_s   = (state_r == ST_DRAIN) && out_ready;
  assign last_col_s = (col_r == CW'(N2 - 1));
  assign k_eff_s    = (k_len > K_LIM) ? K_LIM : k_len;

  // Next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n = (k_eff_s == KW'(0)) ? ST_DRAIN : ST_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s && (cnt_r == KW'(1))) begin
          state_n = ST_FLUSH;
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_r == FW'(1)) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (out_hs_s && last_col_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, beat/flush/column counters and registered handshake flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= KW'(0);
      flush_r     <= FW'(0);
      col_r       <= CW'(0);
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_n;
      if (start_s) begin
        cnt_r <= k_eff_s;
      end else if (accept_s) begin
        cnt_r <= cnt_r - KW'(1);
      end
      if ((state_r == ST_LOAD) && (state_n == ST_FLUSH)) begin
        flush_r <= FW'(FL);
      end else if (state_r == ST_FLUSH) begin
        flush_r <= flush_r - FW'(1);
      end
      if (start_s) begin
        col_r <= CW'(0);
      end else if (out_hs_s) begin
        col_r <= col_r + CW'(1);
      end
      in_ready_r  <= (state_n == ST_LOAD);
      out_valid_r <= (state_n == ST_DRAIN);
      busy_r      <= (state_n != ST_IDLE);
      done_r      <= (state_r == ST_DRAIN) && (state_n == ST_IDLE);
    end
  end

  // Row i of A is delayed by i stages so the wavefront meets B on the diagonal.
  for (genvar i = 0; i < N1; i++) begin : g_a_skew
    assign a_feed_s[i] = (state_r == ST_LOAD) ? A[i*D_W +: D_W] : D_W'(0);
    if (i == 0) begin : g_direct
      assign a_edge_s[i] = a_feed_s[i];
    end else begin : g_chain
      logic signed [D_W-1:0] sk_r [i];
      // Skew shift register, advancing only with the array enable.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < i; k++) sk_r[k] <= D_W'(0);
        end else if (start_s) begin
          for (int k = 0; k < i; k++) sk_r[k] <= D_W'(0);
        end else if (en_s) begin
          sk_r[0] <= a_feed_s[i];
          for (int k = 1; k < i; k++) sk_r[k] <= sk_r[k-1];
        end
      end
      assign a_edge_s[i] = sk_r[i-1];
    end
  end

  for (genvar j = 0; j < N2; j++) begin : g_b_skew
    assign b_feed_s[j] = (state_r == ST_LOAD) ? B[j*D_W +: D_W] : D_W'(0);
    if (j == 0) begin : g_direct
      assign b_edge_s[j] = b_feed_s[j];
    end else begin : g_chain
      logic signed [D_W-1:0] sk_r [j];
      // Skew shift register, advancing only with the array enable.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < j; k++) sk_r[k] <= D_W'(0);
        end else if (start_s) begin
          for (int k = 0; k < j; k++) sk_r[k] <= D_W'(0);
        end else if (en_s) begin
          sk_r[0] <= b_feed_s[j];
          for (int k = 1; k < j; k++) sk_r[k] <= sk_r[k-1];
        end
      end
      assign b_edge_s[j] = sk_r[j-1];
    end
  end

  for (genvar i = 0; i < N1; i++) begin : g_row
    for (genvar j = 0; j < N2; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_in_s[i][j] = a_edge_s[i];
      end else begin : g_a_link
        assign a_in_s[i][j] = a_pe_s[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in_s[i][j] = b_edge_s[j];
      end else begin : g_b_link
        assign b_in_s[i][j] = b_pe_s[i-1][j];
      end
      pe_mac #(
        .D_W      (D_W),
        .D_W_ACC  (D_W_ACC),
        .SATURATE (SATURATE)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (en_s),
        .clr   (start_s),
        .in_a  (a_in_s[i][j]),
        .in_b  (b_in_s[i][j]),
        .out_a (a_pe_s[i][j]),
        .out_b (b_pe_s[i][j]),
        .acc   (acc_s[i][j])
      );
    end
  end

  // Result column select, forced to zero outside DRAIN.
  always_comb begin
    d_s = {(N1*D_W_ACC){1'b0}};
    for (int i = 0; i < N1; i++) begin
      if (out_valid_r) begin
        d_s[i*D_W_ACC +: D_W_ACC] = acc_s[i][col_r];
      end else begin
        d_s[i*D_W_ACC +: D_W_ACC] = {D_W_ACC{1'b0}};
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign D         = d_s;

endmodule

// File: tb/tb_systolic_tile.sv
// Scoreboard bench for systolic_tile: a default 8x4 instance plus two 2x2
// instances with a 16-bit accumulator (wrap and saturate) sharing stimulus.
module tb_systolic_tile;
  import systolic_pkg::*;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int N1 = 8;
  localparam int N2 = 4;
  localparam int KW = 9;
  localparam int SAW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic d_start, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy, d_done;
  logic [KW-1:0] d_klen;
  logic [N1*DW-1:0] d_A;
  logic [N2*DW-1:0] d_B;
  logic [N1*AW-1:0] d_D;

  logic s_start, s_in_valid, s_out_ready;
  logic [KW-1:0] s_klen;
  logic [2*DW-1:0] s_A, s_B;
  logic w_in_ready, w_out_valid, w_busy, w_done;
  logic v_in_ready, v_out_valid, v_busy, v_done;
  logic [2*SAW-1:0] w_D, v_D;

  int checks = 0;
  int passed = 0;

  logic [N1*AW-1:0] q_def[$];
  logic [2*SAW-1:0] q_w[$];
  logic [2*SAW-1:0] q_v[$];
  logic signed [AW-1:0] m_acc [N1][N2];

  systolic_tile u_def (
    .clk(clk), .rst(rst), .start(d_start), .k_len(d_klen),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .A(d_A), .B(d_B),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .D(d_D),
    .busy(d_busy), .done(d_done)
  );

  systolic_tile #(.D_W(8), .D_W_ACC(SAW), .N1(2), .N2(2), .K_MAX(256), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .start(s_start), .k_len(s_klen),
    .in_valid(s_in_valid), .in_ready(w_in_ready), .A(s_A), .B(s_B),
    .out_valid(w_out_valid), .out_ready(s_out_ready), .D(w_D),
    .busy(w_busy), .done(w_done)
  );

  systolic_tile #(.D_W(8), .D_W_ACC(SAW), .N1(2), .N2(2), .K_MAX(256), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .k_len(s_klen),
    .in_valid(s_in_valid), .in_ready(v_in_ready), .A(s_A), .B(s_B),
    .out_valid(v_out_valid), .out_ready(s_out_ready), .D(v_D),
    .busy(v_busy), .done(v_done)
  );

  task automatic start_def(input int k);
    d_klen = k[KW-1:0];
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
  endtask

  // mode 0: all ones, 1: random, 2: all fives; columns pushed only if all k beats fed
  task automatic feed_def(input int k, input int mode, input bit bubbles, input int n_feed);
    logic signed [DW-1:0] av [N1];
    logic signed [DW-1:0] bv [N2];
    int guard;
    for (int i = 0; i < N1; i++) for (int j = 0; j < N2; j++) m_acc[i][j] = '0;
    for (int t = 0; t < n_feed; t++) begin
      if (bubbles) begin
        d_in_valid = 1'b0;
        d_start = 1'b1;
        d_klen = 9'd1;
        @(negedge clk);
        d_start = 1'b0;
      end
      for (int i = 0; i < N1; i++) begin
        av[i] = (mode == 0) ? 8'sd1 : (mode == 2) ? 8'sd5 : 8'($urandom);
        d_A[i*DW +: DW] = av[i];
      end
      for (int j = 0; j < N2; j++) begin
        bv[j] = (mode == 0) ? 8'sd1 : (mode == 2) ? 8'sd5 : 8'($urandom);
        d_B[j*DW +: DW] = bv[j];
      end
      d_in_valid = 1'b1;
      guard = 0;
      while (d_in_ready !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        checks++;
        $display("FAIL feed_timeout: in_ready=%b, required 1 at beat %0d", d_in_ready, t);
      end
      @(negedge clk);
      for (int i = 0; i < N1; i++) for (int j = 0; j < N2; j++)
        m_acc[i][j] = m_acc[i][j] + av[i] * bv[j];
    end
    d_in_valid = 1'b0;
    if (n_feed == k) begin
      for (int j = 0; j < N2; j++) begin
        logic [N1*AW-1:0] col;
        for (int i = 0; i < N1; i++) col[i*AW +: AW] = m_acc[i][j];
        q_def.push_back(col);
      end
    end
  endtask

  task automatic drain_def(input int stall_beat);
    logic [N1*AW-1:0] exp;
    int guard = 0;
    while (d_out_valid !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < N2; c++) begin
      exp = (q_def.size() > 0) ? q_def.pop_front() : '0;
      checks++;
      if (d_out_valid !== 1'b1 || d_D !== exp || d_in_ready !== 1'b0) begin
        $display("FAIL drain_beat%0d: out_valid=%b in_ready=%b D=%h, required 1 0 %h",
                 c, d_out_valid, d_in_ready, d_D, exp);
      end else passed++;
      if (c == stall_beat) begin
        d_out_ready = 1'b0;
        d_in_valid = 1'b1;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (d_out_valid !== 1'b1 || d_D !== exp) begin
            $display("FAIL stall_hold: out_valid=%b D=%h, required 1 %h", d_out_valid, d_D, exp);
          end else passed++;
        end
        d_out_ready = 1'b1;
        d_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (d_done !== 1'b1 || d_out_valid !== 1'b0 || d_busy !== 1'b0 || d_D !== '0) begin
      $display("FAIL done_pulse: done=%b out_valid=%b busy=%b D=%h, required 1 0 0 0",
               d_done, d_out_valid, d_busy, d_D);
    end else passed++;
    @(negedge clk);
    checks++;
    if (d_done !== 1'b0 || d_out_valid !== 1'b0) begin
      $display("FAIL done_single: done=%b out_valid=%b, required 0 0", d_done, d_out_valid);
    end else passed++;
  endtask

  task automatic run_small(input int k, input logic [2*DW-1:0] a, input logic [2*DW-1:0] b);
    int guard;
    s_klen = k[KW-1:0];
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_A = a;
    s_B = b;
    for (int t = 0; t < k; t++) begin
      s_in_valid = 1'b1;
      guard = 0;
      while (w_in_ready !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        checks++;
        $display("FAIL small_feed_timeout: in_ready=%b, required 1", w_in_ready);
      end
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    guard = 0;
    while (w_out_valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 2; c++) begin
      logic [2*SAW-1:0] ew, ev;
      ew = (q_w.size() > 0) ? q_w.pop_front() : '0;
      ev = (q_v.size() > 0) ? q_v.pop_front() : '0;
      checks++;
      if (w_out_valid !== 1'b1 || w_D !== ew) begin
        $display("FAIL wrap_beat%0d: out_valid=%b D=%h, required 1 %h", c, w_out_valid, w_D, ew);
      end else passed++;
      checks++;
      if (v_out_valid !== 1'b1 || v_D !== ev) begin
        $display("FAIL sat_beat%0d: out_valid=%b D=%h, required 1 %h", c, v_out_valid, v_D, ev);
      end else passed++;
      @(negedge clk);
    end
    checks++;
    if (w_done !== 1'b1 || v_done !== 1'b1 || w_busy !== 1'b0) begin
      $display("FAIL small_done: done=%b/%b busy=%b, required 1/1 0", w_done, v_done, w_busy);
    end else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    d_start = 1'b0; d_klen = '0; d_in_valid = 1'b0; d_A = '0; d_B = '0; d_out_ready = 1'b1;
    s_start = 1'b0; s_klen = '0; s_in_valid = 1'b0; s_A = '0; s_B = '0; s_out_ready = 1'b1;
    #1;
    checks++;
    if ({d_in_ready, d_out_valid, d_busy, d_done} !== 4'b0000 || d_D !== '0 ||
        {w_in_ready, w_out_valid, w_busy, w_done} !== 4'b0000 || w_D !== '0) begin
      $display("FAIL reset_state: flags=%b%b%b%b D=%h, required 0000 0",
               d_in_ready, d_out_valid, d_busy, d_done, d_D);
    end else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small_basic();
    q_w.push_back(32'h000C_0008); q_w.push_back(32'h000F_000A);
    q_v.push_back(32'h000C_0008); q_v.push_back(32'h000F_000A);
    run_small(1, {8'sd3, 8'sd2}, {8'sd5, 8'sd4});
  endtask

  task automatic test_saturate();
    q_w.push_back(32'h8000_8000); q_w.push_back(32'h8000_8000);
    q_v.push_back(32'h7FFF_7FFF); q_v.push_back(32'h7FFF_7FFF);
    run_small(2, 16'h8080, 16'h8080);
  endtask

  task automatic test_bubbles();
    start_def(3);
    feed_def(3, 0, 1'b1, 3);
    drain_def(-1);
  endtask

  task automatic test_random();
    start_def(5);
    feed_def(5, 1, 1'b0, 5);
    drain_def(-1);
  endtask

  task automatic test_stall();
    start_def(2);
    feed_def(2, 2, 1'b0, 2);
    drain_def(1);
  endtask

  task automatic test_reset_mid();
    start_def(4);
    feed_def(4, 2, 1'b0, 2);
    rst = 1'b0;
    #1;
    checks++;
    if ({d_in_ready, d_out_valid, d_busy, d_done} !== 4'b0000 || d_D !== '0) begin
      $display("FAIL reset_mid: flags=%b%b%b%b, required 0000",
               d_in_ready, d_out_valid, d_busy, d_done);
    end else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_def(1);
    feed_def(1, 0, 1'b0, 1);
    drain_def(-1);
  endtask

  task automatic test_zero_len();
    d_in_valid = 1'b1;
    d_A = {N1{8'sd7}};
    d_B = {N2{8'sd7}};
    for (int j = 0; j < N2; j++) q_def.push_back('0);
    start_def(0);
    drain_def(-1);
    d_in_valid = 1'b0;
  endtask

  task automatic test_clamp();
    start_def(300);
    feed_def(256, 0, 1'b0, 256);
    drain_def(-1);
  endtask

  initial begin
    test_reset();
    test_small_basic();
    test_saturate();
    test_bubbles();
    test_random();
    test_stall();
    test_reset_mid();
    test_zero_len();
    test_clamp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/systolic_tile.md
SYSTOLIC_TILE -- requirements
Module: systolic_tile

Interface
REQ-001: Parameter D_W, default 8, signed operand width.
REQ-002: Parameter D_W_ACC, default 32, signed accumulator width (SHALL be >= 2*D_W).
REQ-003: Parameter N1, default 8, PE rows (>= 2).
REQ-004: Parameter N2, default 4, PE columns (>= 2).
REQ-005: Parameter K_MAX, default 256, maximum reduction length; KW = clog2(K_MAX+1).
REQ-006: Parameter SATURATE, default 0; 1 = clamp accumulators, 0 = two's-complement wrap.
REQ-007: clk  input  1  single clock; all state updates on rising edge.
REQ-008: rst  input  1  asynchronous, active-low reset.
REQ-009: start  input  1  begin a tile; sampled only in IDLE.
REQ-010: k_len  input  KW  reduction length, sampled with start; values > K_MAX are clamped to K_MAX.
REQ-011: in_valid / in_ready  input / output  1 each  operand-beat handshake.
REQ-012: A  input  N1*D_W  signed column of A; row i at bits [i*D_W +: D_W].
REQ-013: B  input  N2*D_W  signed row of B; column j at bits [j*D_W +: D_W].
REQ-014: out_valid / out_ready  output / input  1 each  result-beat handshake.
REQ-015: D  output  N1*D_W_ACC  one result column; row i at [i*D_W_ACC +: D_W_ACC].
REQ-016: busy  output  1  high whenever state != IDLE.
REQ-017: done  output  1  single-cycle pulse on tile completion.

Function
REQ-018: FSM states IDLE, LOAD, FLUSH, DRAIN; IDLE->LOAD on start with k_len>0; IDLE->DRAIN on start with k_len==0.
REQ-019: On the start edge every PE accumulator SHALL clear to 0 and the beat counter SHALL load k_len.
REQ-020: in_ready SHALL equal (state==LOAD); a beat is accepted on in_valid && in_ready.
REQ-021: Array enable = (LOAD && in_valid) || FLUSH; with enable low, all skew, PE and accumulator registers hold (bubbles do not alter results).
REQ-022: Row i of A passes i skew registers, column j of B passes j skew registers, before entering PE(i,0) / PE(0,j).
REQ-023: Each enabled PE registers out_a<=in_a, out_b<=in_b, acc<=acc+in_a*in_b (full-precision signed product, sign-extended to D_W_ACC).
REQ-024: Accepted beat k SHALL reach PE(i,j) on enabled edge k+i+j, counting from the first accepted beat.
REQ-025: LOAD->FLUSH on acceptance of beat k_len-1; FLUSH feeds zero operands for exactly N1+N2-2 cycles, then ->DRAIN.
REQ-026: SATURATE=1: sums above 2^(D_W_ACC-1)-1 or below -2^(D_W_ACC-1) clamp to those limits; SATURATE=0: wrap modulo 2^D_W_ACC.
REQ-027: DRAIN emits N2 beats, beat c presenting acc[i][c] for all i, c ascending from 0; out_valid=1 throughout DRAIN.
REQ-028: Beat advances only on out_valid && out_ready; while out_ready=0, D and out_valid SHALL remain stable.
REQ-029: After handshake of beat N2-1: ->IDLE, done=1 for exactly the next cycle.
REQ-030: start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-031: D SHALL be 0 whenever out_valid=0.

Reset
REQ-032: rst low SHALL immediately force IDLE, all accumulators/skew/PE registers to 0, and in_ready, out_valid, busy, done, D to 0.
REQ-033: Reset mid-tile SHALL discard the tile; the next start after rst release SHALL produce results free of residue.

Structure
REQ-034: Shared package systolic_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-035: One sub-module, pe_mac (enable, clear, registered a/b passthrough, accumulator, saturation option), SHALL be instantiated N1*N2 times.

Verification
REQ-036: N1=N2=2, k_len=1, A rows {2,3}, B cols {4,5} -> beat0 D={8,12}, beat1 D={10,15}, done pulse.
REQ-037: Default size, k_len=3, all A=B=1, in_valid low every other cycle -> 4 beats, all D rows = 3.
REQ-038: Drain with out_ready low 5 cycles at beat 1 -> D/out_valid stable, exactly 4 beats total, values unchanged.
REQ-039: D_W=8, D_W_ACC=16, k_len=2, all A=B=-128 -> SATURATE=0 gives -32768, SATURATE=1 gives 32767.
REQ-040: rst low mid-LOAD, then start k_len=1, A=B=1 -> all D=1, no prior-tile residue.
REQ-041: start with k_len=0 -> IDLE->DRAIN, 4 beats of zero, done pulse, in_ready never high.
